// File: rtl/wdm_fifo_writer.sv
// Purpose: write-side companion of the packet FIFO reader; moves an upstream byte stream into the FIFO.
// Latency: 1 cycle from an accepted input byte to o_fifo_wr when the elastic buffer is empty.
// Backpressure: i_fifo_full/i_fifo_af stall writes into a DEPTH-entry elastic buffer; bytes are dropped only when it overflows.
module wdm_fifo_writer #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_data_wr,
  input  logic [DW-1:0] iv_data,
  input  logic          i_fifo_full,
  input  logic          i_fifo_af,
  output logic          o_fifo_wr,
  output logic [DW-1:0] ov_fifo_data,
  output logic          o_overflow,
  output logic [7:0]    ov_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Reset is applied to the logic immediately but released only on a clock
  // edge, two flops deep, so no flop sees a reset release near the edge.
  logic rst_meta;
  logic rst_sync;

  // Reset synchroniser: asynchronous assert, synchronous release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Elastic buffer storage and bookkeeping.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic allow;
  logic buf_empty;
  logic buf_full;
  logic pop;
  logic bypass;
  logic push;
  logic drop;

  // Per-cycle decisions: who drives the FIFO port and what happens to the input byte.
  always_comb begin
    buf_empty = (count == '0);
    buf_full  = (count == FULL_CNT);
    // While almost full, a write is never issued in the cycle right after
    // another one; that gap covers the FIFO's flag update lag.
    allow     = !i_fifo_full && (!i_fifo_af || !o_fifo_wr);
    // Buffered bytes always go first so ordering is kept.
    pop       = !buf_empty && allow;
    bypass    = buf_empty && i_data_wr && allow;
    // A full buffer still accepts a byte when its head leaves on the same edge.
    push      = i_data_wr && !bypass && (!buf_full || pop);
    drop      = i_data_wr && !bypass && buf_full && !pop;
  end

  // Buffer storage write; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= iv_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge rst_sync) begin
    if (rst_sync) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered FIFO write port; data holds its last value when no write is issued.
  always_ff @(posedge i_clk or posedge rst_sync) begin
    if (rst_sync) begin
      o_fifo_wr    <= 1'b0;
      ov_fifo_data <= '0;
    end else begin
      o_fifo_wr <= pop || bypass;
      if (pop) begin
        ov_fifo_data <= mem[rd_ptr];
      end else if (bypass) begin
        ov_fifo_data <= iv_data;
      end
    end
  end

  // Overflow pulse and saturating dropped-byte counter.
  always_ff @(posedge i_clk or posedge rst_sync) begin
    if (rst_sync) begin
      o_overflow  <= 1'b0;
      ov_drop_cnt <= 8'd0;
    end else begin
      o_overflow <= drop;
      if (drop && (ov_drop_cnt != 8'hFF)) begin
        ov_drop_cnt <= ov_drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wdm_fifo_writer.sv
// Bench for wdm_fifo_writer: directed test-plan scenarios followed by a random
// soak, all checked every cycle against a queue-based model of the byte flow.
module tb_wdm_fifo_writer;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          i_clk;
  logic          i_rst;
  logic          i_data_wr;
  logic [DW-1:0] iv_data;
  logic          i_fifo_full;
  logic          i_fifo_af;
  logic          o_fifo_wr;
  logic [DW-1:0] ov_fifo_data;
  logic          o_overflow;
  logic [7:0]    ov_drop_cnt;

  wdm_fifo_writer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data_wr    (i_data_wr),
    .iv_data      (iv_data),
    .i_fifo_full  (i_fifo_full),
    .i_fifo_af    (i_fifo_af),
    .o_fifo_wr    (o_fifo_wr),
    .ov_fifo_data (ov_fifo_data),
    .o_overflow   (o_overflow),
    .ov_drop_cnt  (ov_drop_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bytes waiting in the elastic buffer plus the FIFO port view.
  logic [DW-1:0] m_q[$];
  logic          m_wr;
  logic [DW-1:0] m_data;
  logic          m_ovf;
  int            m_drop;
  int            wr_pulses;
  int            ovf_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wr   = 1'b0;
    m_data = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One clock edge of the byte-flow rules, expressed on the queue.
  task automatic model_edge(input logic dv, input logic [DW-1:0] d, input logic f, input logic a);
    logic ok;
    logic taken;
    ok    = !f && (!a || !m_wr);
    taken = 1'b0;
    if (m_q.size() > 0 && ok) begin
      m_data = m_q.pop_front();
      m_wr   = 1'b1;
    end else if (dv && ok) begin
      m_data = d;
      m_wr   = 1'b1;
      taken  = 1'b1;
    end else begin
      m_wr = 1'b0;
    end
    m_ovf = 1'b0;
    if (dv && !taken) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(d);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    check("fifo_wr", {31'd0, o_fifo_wr}, {31'd0, m_wr});
    check("fifo_data", {24'd0, ov_fifo_data}, {24'd0, m_data});
    check("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    check("drop_cnt", {24'd0, ov_drop_cnt}, 32'(m_drop));
    check("buf_count", 32'(dut.count), 32'(m_q.size()));
  endtask

  task automatic step(input logic dv, input logic [DW-1:0] d, input logic f, input logic a);
    @(negedge i_clk);
    i_data_wr   = dv;
    iv_data     = d;
    i_fifo_full = f;
    i_fifo_af   = a;
    model_edge(dv, d, f, a);
    @(posedge i_clk);
    #1;
    compare_all();
    if (o_fifo_wr) wr_pulses++;
    if (o_overflow) ovf_pulses++;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    // Idle cycles cover the synchronous reset release inside the design.
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_data_wr   = 1'b0;
    iv_data     = '0;
    i_fifo_full = 1'b0;
    i_fifo_af   = 1'b0;
    wr_pulses   = 0;
    ovf_pulses  = 0;
    model_reset();
    #12;
    check("reset_wr", {31'd0, o_fifo_wr}, 32'd0);
    check("reset_drop", {24'd0, ov_drop_cnt}, 32'd0);
    do_reset();

    // Back-to-back stream at full rate.
    wr_pulses = 0;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("b2b_writes", 32'(wr_pulses), 32'd16);

    // Almost-full throttling: alternate-cycle writes.
    wr_pulses = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("af_writes", 32'(wr_pulses), 32'd6);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Overflow while the FIFO is full.
    ovf_pulses = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf_pulses", 32'(ovf_pulses), 32'd2);
    check("ovf_drop_cnt", {24'd0, ov_drop_cnt}, 32'd2);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous push and pop with a full buffer.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h31 + i), 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("pushpop_count", 32'(dut.count), 32'd4);
    check("pushpop_nodrop", {31'd0, o_overflow}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Drop counter saturation.
    ovf_pulses = 0;
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    check("sat_drop_cnt", {24'd0, ov_drop_cnt}, 32'd255);
    check("sat_pulses", 32'(ovf_pulses), 32'd296);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-stream: three bytes buffered and a write in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_wr", {31'd0, o_fifo_wr}, 32'd1);
    check("pre_rst_count", 32'(dut.count), 32'd3);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_wr", {31'd0, o_fifo_wr}, 32'd0);
    check("async_rst_count", 32'(dut.count), 32'd0);
    check("async_rst_drop", {24'd0, ov_drop_cnt}, 32'd0);
    do_reset();
    wr_pulses = 0;
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_writes", 32'(wr_pulses), 32'd4);

    // Random soak.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom),
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
